// File: rtl/inv_mix_columns_pkg.sv
// rtl/inv_mix_columns_pkg.sv - shared AES types, field polynomial and xtime helper
package aes_pkg;

   localparam logic [7:0] AES_POLY = 8'h1B;

   typedef logic [127:0] state_t;
   typedef logic [31:0]  col_t;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } fsm_t;

   // Multiply by x in GF(2^8), reducing by the AES polynomial on overflow.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_columns_if.sv
// rtl/inv_mix_columns_if.sv - state in/out handshake bundle for the InvMixColumns engine
interface inv_mix_columns_if;
   import aes_pkg::*;

   state_t in_state;
   logic   in_valid;
   logic   in_ready;
   state_t out_state;
   logic   out_valid;
   logic   out_ready;

   modport master (
      output in_state, in_valid, out_ready,
      input  in_ready, out_state, out_valid
   );

   modport slave (
      input  in_state, in_valid, out_ready,
      output in_ready, out_state, out_valid
   );

endinterface

// File: rtl/inv_mix_columns_col.sv
// rtl/inv_mix_columns_col.sv - combinational InvMixColumns of one 32-bit column
module inv_mix_col
   import aes_pkg::*;
(
   input  col_t i_col,
   output col_t o_col
);

   logic [7:0] w_a   [4];
   logic [7:0] w_x2  [4];
   logic [7:0] w_x4  [4];
   logic [7:0] w_x8  [4];
   logic [7:0] w_m9  [4];
   logic [7:0] w_m11 [4];
   logic [7:0] w_m13 [4];
   logic [7:0] w_m14 [4];

   // 9, 11, 13 and 14 are sums of the x2/x4/x8 chain plus the byte itself.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_a[i]   = i_col[31 - 8*i -: 8];
         w_x2[i]  = xtime(w_a[i]);
         w_x4[i]  = xtime(w_x2[i]);
         w_x8[i]  = xtime(w_x4[i]);
         w_m9[i]  = w_x8[i] ^ w_a[i];
         w_m11[i] = w_x8[i] ^ w_x2[i] ^ w_a[i];
         w_m13[i] = w_x8[i] ^ w_x4[i] ^ w_a[i];
         w_m14[i] = w_x8[i] ^ w_x4[i] ^ w_x2[i];
      end
   end

   assign o_col[31:24] = w_m14[0] ^ w_m11[1] ^ w_m13[2] ^ w_m9[3];
   assign o_col[23:16] = w_m9[0]  ^ w_m14[1] ^ w_m11[2] ^ w_m13[3];
   assign o_col[15:8]  = w_m13[0] ^ w_m9[1]  ^ w_m14[2] ^ w_m11[3];
   assign o_col[7:0]   = w_m11[0] ^ w_m13[1] ^ w_m9[2]  ^ w_m14[3];

endmodule

// File: rtl/inv_mix_columns.sv
// rtl/inv_mix_columns.sv - iterative in-place InvMixColumns engine with valid/ready handshake
module inv_mix_columns
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic               clk,
   input  logic               rst,
   inv_mix_columns_if.slave   bus
);

   localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);
   localparam logic [1:0] CNT_STEP  = 2'(COLS_PER_CYCLE);

   fsm_t       r_fsm;
   fsm_t       w_fsm_next;
   logic [1:0] r_col_cnt;
   state_t     r_state;
   state_t     w_state_next;
   logic       w_last;

   col_t       w_cols    [4];
   col_t       w_col_in  [COLS_PER_CYCLE];
   col_t       w_col_out [COLS_PER_CYCLE];
   logic [1:0] w_idx     [COLS_PER_CYCLE];

   assign w_last = (r_col_cnt == LAST_BASE);

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         w_cols[c] = r_state[127 - 32*c -: 32];
      end
   end

   // col_cnt stays a multiple of COLS_PER_CYCLE, so the group never wraps mid-way.
   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign w_idx[g]    = r_col_cnt + 2'(g);
      assign w_col_in[g] = w_cols[w_idx[g]];

      inv_mix_col u_col (
         .i_col (w_col_in[g]),
         .o_col (w_col_out[g])
      );
   end

   always_comb begin
      w_state_next = r_state;
      for (int g = 0; g < COLS_PER_CYCLE; g++) begin
         w_state_next[127 - 32*int'(w_idx[g]) -: 32] = w_col_out[g];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fsm <= IDLE;
      end else begin
         r_fsm <= w_fsm_next;
      end
   end

   always_comb begin
      w_fsm_next = r_fsm;
      case (r_fsm)
         IDLE:    if (bus.in_valid)  w_fsm_next = BUSY;
         BUSY:    if (w_last)        w_fsm_next = DONE;
         DONE:    if (bus.out_ready) w_fsm_next = IDLE;
         default: w_fsm_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= '0;
         r_col_cnt <= 2'd0;
      end else begin
         case (r_fsm)
            IDLE: begin
               if (bus.in_valid) begin
                  r_state   <= bus.in_state;
                  r_col_cnt <= 2'd0;
               end
            end
            BUSY: begin
               r_state   <= w_state_next;
               r_col_cnt <= r_col_cnt + CNT_STEP;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (r_fsm == IDLE);
   assign bus.out_valid = (r_fsm == DONE);
   assign bus.out_state = r_state;

endmodule

// File: tb/tb_inv_mix_columns.sv
// tb/tb_inv_mix_columns.sv - self-checking bench for inv_mix_columns at 1, 2 and 4 columns per cycle
module tb_inv_mix_columns;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   always #5 clk = ~clk;

   inv_mix_columns_if if1 ();
   inv_mix_columns_if if2 ();
   inv_mix_columns_if if4 ();

   inv_mix_columns #(.COLS_PER_CYCLE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
   inv_mix_columns #(.COLS_PER_CYCLE(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
   inv_mix_columns #(.COLS_PER_CYCLE(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

   // Reference GF(2^8) product: carry-less multiply then polynomial long division by 0x11B.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      p = 16'h0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({8'h00, a} << i);
      for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
      return p[7:0];
   endfunction

   // Circulant matrix product per column; inv selects {14,11,13,9}, else {2,3,1,1}.
   function automatic logic [127:0] mix(input logic [127:0] s, input bit inv);
      logic [7:0]   k [4];
      logic [7:0]   a [4];
      logic [7:0]   r;
      logic [127:0] o;
      if (inv) begin k[0] = 8'd14; k[1] = 8'd11; k[2] = 8'd13; k[3] = 8'd9; end
      else     begin k[0] = 8'd2;  k[1] = 8'd3;  k[2] = 8'd1;  k[3] = 8'd1; end
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
         for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r = r ^ gmul(k[(j - i + 4) % 4], a[j]);
            o[127 - 32*c - 8*i -: 8] = r;
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] rnd_state();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic accept1(input logic [127:0] s);
      if1.in_state = s;
      if1.in_valid = 1'b1;
      tick();
      if1.in_valid = 1'b0;
   endtask

   task automatic wait_out1(output int lat);
      lat = 0;
      while (!if1.out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release1();
      if1.out_ready = 1'b1;
      tick();
      if1.out_ready = 1'b0;
   endtask

   logic [127:0] s, s_fwd, q [3], res [3];
   int           t [3];
   int           lat, lat1, lat2, lat4, k, got;
   bit           acc;

   initial begin
      if1.in_state = '0; if1.in_valid = 1'b1; if1.out_ready = 1'b0;
      if2.in_state = '0; if2.in_valid = 1'b0; if2.out_ready = 1'b0;
      if4.in_state = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b0;
      if1.in_state = 128'hdeadbeef_00112233_44556677_8899aabb;

      // In reset: in_valid is ignored and outputs sit at reset values.
      tick(); tick();
      chk("rst_out_state", if1.out_state, '0);
      chk("rst_out_valid", if1.out_valid, 1'b0);
      chk("rst_in_ready",  if1.in_ready,  1'b1);
      if1.in_valid = 1'b0;
      rst = 1'b0;
      tick();
      chk("idle_in_ready", if1.in_ready, 1'b1);

      // Single column, latency 4.
      accept1({32'h8e4da1bc, 96'h0});
      chk("single_in_ready_low", if1.in_ready, 1'b0);
      wait_out1(lat);
      chk("single_latency", lat, 4);
      chk("single_result", if1.out_state, {32'hdb135345, 96'h0});
      release1();
      chk("single_ready_after_hs", if1.in_ready, 1'b1);
      chk("single_valid_after_hs", if1.out_valid, 1'b0);

      // Full state plus random states on all three widths together.
      for (int it = 0; it < 21; it++) begin
         s = (it == 0) ? {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6} : rnd_state();
         if1.in_state = s; if2.in_state = s; if4.in_state = s;
         if1.in_valid = 1'b1; if2.in_valid = 1'b1; if4.in_valid = 1'b1;
         tick();
         if1.in_valid = 1'b0; if2.in_valid = 1'b0; if4.in_valid = 1'b0;
         lat1 = -1; lat2 = -1; lat4 = -1;
         for (int n = 1; n <= 8; n++) begin
            tick();
            if (if1.out_valid && lat1 < 0) lat1 = n;
            if (if2.out_valid && lat2 < 0) lat2 = n;
            if (if4.out_valid && lat4 < 0) lat4 = n;
         end
         if (it == 0) begin
            chk("full_c1", if1.out_state, {32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6});
            chk("full_c2", if2.out_state, {32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6});
            chk("full_c4", if4.out_state, {32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6});
            chk("lat_c1", lat1, 4);
            chk("lat_c2", lat2, 2);
            chk("lat_c4", lat4, 1);
         end else begin
            chk("rand_c1", if1.out_state, mix(s, 1'b1));
            chk("rand_c2", if2.out_state, mix(s, 1'b1));
            chk("rand_c4", if4.out_state, mix(s, 1'b1));
         end
         if1.out_ready = 1'b1; if2.out_ready = 1'b1; if4.out_ready = 1'b1;
         tick();
         if1.out_ready = 1'b0; if2.out_ready = 1'b0; if4.out_ready = 1'b0;
         chk("ready_c1", if1.in_ready, 1'b1);
         chk("ready_c2", if2.in_ready, 1'b1);
         chk("ready_c4", if4.in_ready, 1'b1);
      end

      // Backpressure: hold DONE for 10 cycles while upstream waves new data.
      s = rnd_state();
      accept1(s);
      wait_out1(lat);
      chk("bp_latency", lat, 4);
      for (int n = 0; n < 10; n++) begin
         if1.in_valid = 1'b1;
         if1.in_state = rnd_state();
         tick();
         chk("bp_state", if1.out_state, mix(s, 1'b1));
         chk("bp_valid", if1.out_valid, 1'b1);
         chk("bp_in_ready", if1.in_ready, 1'b0);
      end
      if1.in_valid = 1'b0;
      release1();
      chk("bp_release_ready", if1.in_ready, 1'b1);
      chk("bp_release_valid", if1.out_valid, 1'b0);

      // Back-to-back with in_valid held and out_ready tied high.
      for (int i = 0; i < 3; i++) q[i] = rnd_state();
      k = 0; got = 0;
      if1.out_ready = 1'b1;
      for (int n = 0; n < 60 && got < 3; n++) begin
         if (k < 3) begin
            if1.in_valid = 1'b1;
            if1.in_state = q[k];
         end else begin
            if1.in_valid = 1'b0;
         end
         acc = if1.in_ready && (k < 3);
         if (if1.out_valid) begin
            res[got] = if1.out_state;
            t[got]   = cyc;
            got++;
         end
         tick();
         if (acc) k++;
      end
      if1.in_valid = 1'b0;
      if1.out_ready = 1'b0;
      chk("b2b_count", got, 3);
      if (got == 3) begin
         for (int i = 0; i < 3; i++) chk("b2b_result", res[i], mix(q[i], 1'b1));
         chk("b2b_gap01", t[1] - t[0], 6);
         chk("b2b_gap12", t[2] - t[1], 6);
      end

      // Reset two cycles after accept: asynchronous abort.
      accept1(rnd_state());
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("midrst_state", if1.out_state, '0);
      chk("midrst_valid", if1.out_valid, 1'b0);
      chk("midrst_ready", if1.in_ready,  1'b1);
      tick();
      rst = 1'b0;
      tick();
      s = rnd_state();
      accept1(s);
      wait_out1(lat);
      chk("postrst_latency", lat, 4);
      chk("postrst_result", if1.out_state, mix(s, 1'b1));
      release1();

      // Round trip through forward MixColumns.
      for (int n = 0; n < 1000; n++) begin
         s = rnd_state();
         s_fwd = mix(s, 1'b0);
         accept1(s_fwd);
         wait_out1(lat);
         chk("roundtrip", if1.out_state, s);
         release1();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Iterative AES InvMixColumns engine for the decryption datapath. It accepts a full 128-bit AES state and applies the inverse MixColumns transform column by column, in place. It returns the transformed state through a valid/ready handshake. It is the inverse of the existing single-column forward MixColumns block and sits between InvShiftRows/InvSubBytes and AddRoundKey in the decrypt round.

## Interface
- COLS_PER_CYCLE, default 1: columns transformed per BUSY cycle; legal values 1, 2, 4.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_state  in  128  input AES state; column c = bits [127-32c -: 32]; within a column, bits [31:24] = row 0 … bits [7:0] = row 3.
- in_valid  in  1  in_state is valid.
- in_ready  out  1  engine can accept a state; equals (fsm == IDLE).
- out_state  out  128  transformed state; same column/row packing as in_state.
- out_valid  out  1  out_state is valid; high only in DONE.
- out_ready  in  1  consumer accepts out_state.

## Operation
- Per column (a0..a3 = rows 0..3), all arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1:
  - r0 = 14·a0 ^ 11·a1 ^ 13·a2 ^ 9·a3
  - r1 = 9·a0 ^ 14·a1 ^ 11·a2 ^ 13·a3
  - r2 = 13·a0 ^ 9·a1 ^ 14·a2 ^ 11·a3
  - r3 = 11·a0 ^ 13·a1 ^ 9·a2 ^ 14·a3
- Multiplies are built from xtime chains (x2, x4, x8) and XORs. No lookup tables and no generic multiplier.
- FSM has three states:
  - IDLE: in_ready=1. When in_valid=1 at an edge, the engine loads in_state into the state register, clears col_cnt and moves to BUSY.
  - BUSY: each edge replaces columns col_cnt … col_cnt+COLS_PER_CYCLE-1 with their transformed values and advances col_cnt by COLS_PER_CYCLE. On the edge that processes column 3, the FSM moves to DONE.
  - DONE: out_valid=1. When out_ready=1 at an edge, the FSM moves to IDLE. Otherwise it holds, and out_state stays stable.
- col_cnt is 2 bits. It wraps to 0 after the last column. Its value in IDLE and DONE is don't-care but deterministic: it is 0 after the wrap.
- out_state is driven directly from the state register. Intermediate values are visible during BUSY, but out_valid=0 then, so consumers ignore them.
- in_valid in BUSY or DONE is ignored. The upstream stage must hold in_valid and in_state until in_ready.
- out_ready in IDLE or BUSY is ignored.
- Only one transform is in flight at a time. A new accept is not allowed in the same cycle as the out handshake.

## Timing
- Reset values (asserted asynchronously; takes effect immediately):
  - fsm = IDLE, col_cnt = 0, state register = 0.
  - Outputs: out_state = 0, out_valid = 0, in_ready = 1.
- While rst=1, in_valid is ignored.
- Reset asserted during BUSY or DONE aborts the block. No output is produced for it.
- Latency: accept edge E0. out_valid rises after edge E0+4/COLS_PER_CYCLE, i.e. E4, E2 or E1.
- Throughput with out_ready tied high: one state per 4/COLS_PER_CYCLE + 2 cycles (6 cycles for COLS_PER_CYCLE=1).
- in_ready falls the cycle after accept. It rises the cycle after the out handshake edge.

## Structure
- Shared package aes_pkg holds:
  - AES_POLY = 8'h1B.
  - the xtime function.
  - the state_t (128-bit) and col_t (32-bit) typedefs.
  - the fsm_t enum {IDLE, BUSY, DONE}.
- Sub-module inv_mix_col: purely combinational, col_t in to col_t out. The top instantiates COLS_PER_CYCLE copies, indexed from col_cnt.
- Top file contains the FSM, col_cnt, the state register and handshake logic only.

## Test plan
- Single column check, COLS_PER_CYCLE=1: column 0 = 32'h8e4da1bc, other columns 0. Expect out column 0 = 32'hdb135345 and other columns 0. out_valid rises exactly 4 cycles after accept.
- Full state: columns {32'hd5d5d7d6, 32'h4d7ebdf8, 32'h01010101, 32'hc6c6c6c6}. Expect {32'hd4d4d4d5, 32'h2d26314c, 32'h01010101, 32'hc6c6c6c6}. Repeat for COLS_PER_CYCLE=2 and 4, checking latency 2 and 1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. Expect out_state and out_valid stable, in_ready=0, and a changed in_valid/in_state ignored. Releasing out_ready returns the FSM to IDLE on the next edge.
- Back-to-back: in_valid held high with 3 distinct states and out_ready=1. Expect 3 correct results in order, 6 cycles apart (COLS_PER_CYCLE=1).
- Reset mid-BUSY: assert rst 2 cycles after accept. Expect out_state=0, out_valid=0 and in_ready=1 immediately. The next accepted state then produces its correct result.
- Round trip: 1000 random states passed through 4 forward MixColumns single-column instances, then through inv_mix_columns. Expect output equal to the original state in every case.
